execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- EX stage of the 16-bit pipelined CPU: ALU-control decode, 16-bit signed ALU and the EX/MEM pipeline register.
- Inputs come from the ID/EX buffer: operands, funct, ALUOP, control bits and destination register.
- Registered outputs feed the data memory and the MEM/WB buffer.

Parameters:
- WIDTH, 16, datapath width; only 16 is supported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous: next EX/MEM contents become a bubble
- alu_op  in  2  ALUOP from control
- funct  in  4  instruction funct field
- rd1  in  16  operand 1
- rd2  in  16  register operand 2
- imm  in  16  sign-extended immediate
- alu_src  in  1  1 selects imm as operand 2, 0 selects rd2
- mov_op_in  in  4  move/destination field (IFID_RT) carried to WB
- reg_rd_in  in  4  destination register number
- mem_to_reg_in, mem_write_in, mem_read_in, r15_in, reg_write_in  in  1 each  control bits
- operation  out  4  combinational decoded ALU operation
- result  out  16  combinational ALU result
- remainder  out  16  combinational secondary result
- overflow  out  1  combinational overflow / error flag
- alu_result_out, alu_remainder_out  out  16  registered result and remainder
- mov_op_out, reg_rd_out  out  4  registered fields
- mem_to_reg_out, mem_write_out, mem_read_out, r15_out, reg_write_out  out  1  registered control bits

Behaviour:
- ALU control (combinational):
  - alu_op=00: ADD (address calculation).
  - alu_op=01: SUB (branch compare).
  - alu_op=11: PASS B.
  - alu_op=10: decode funct.
- Funct decode for alu_op=10:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 MUL, 0101 DIV.
  - 0110 SLL, 0111 SRL, 1000 SRA, 1001 PASS B.
  - Any other funct gives NOP.
- Operation encodings equal the funct codes listed above; NOP = 1111.
- Operand B = alu_src ? imm : rd2. All arithmetic is two's-complement signed.
- ADD/SUB:
  - result = 16-bit wrap; remainder = 0.
  - overflow = signed overflow (operand signs agree and result sign differs; for SUB, B's sign is inverted).
- AND/OR: bitwise; remainder = 0; overflow = 0.
- MUL:
  - 32-bit signed product; result = low 16 bits, remainder = high 16 bits.
  - overflow = 1 when the high half is not the sign extension of result.
- DIV:
  - Signed division, truncates toward zero; result = quotient, remainder takes the dividend's sign.
  - B=0: result=0, remainder=A, overflow=1.
  - A=0x8000 with B=0xFFFF: result=0x8000, remainder=0, overflow=1.
- Shifts: amount = B[3:0]; SRA is arithmetic; remainder = 0; overflow = 0.
- PASS B: result = B. NOP: result = 0. Both give remainder = 0 and overflow = 0.
- EX/MEM register:
  - On every rising clk, latches result, remainder, mov_op_in, reg_rd_in and all five control bits; one-cycle latency.
  - flush=1 at the edge: every registered output loads 0 (a bubble; reg_write_out and mem_write_out are guaranteed 0).
  - reset low: all registered outputs immediately 0, independent of clk, held until reset goes high. First capture happens on the first rising edge after release.
- No stall input; the register updates on every cycle.

Optional Feature:
- Macro EXEC_ZERO_FLAG_EN.
- Defined: adds output zero (1 bit, combinational, result==0) and zero_out (1 bit, registered with the other EX/MEM fields, cleared by reset and flush). Branch logic uses these.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- Reset low mid-run with nonzero outputs -> all registered outputs 0 immediately. Release, then alu_op=00, rd1=0x0005, rd2=0x0003 -> alu_result_out=0x0008 after one edge.
- alu_op=10, funct=0000, rd1=0x7FFF, rd2=0x0001 -> result=0x8000, overflow=1. funct=0001, rd1=0x0003, rd2=0x0005 -> result=0xFFFE, overflow=0.
- funct=0100, rd1=0x0100, rd2=0x0100 -> result=0x0000, remainder=0x0001, overflow=1. funct=0101, rd1=0xFFF9 (-7), rd2=0x0002 -> result=0xFFFD, remainder=0xFFFF.
- funct=0101, rd2=0 -> result=0, remainder=rd1, overflow=1. alu_src=1, alu_op=11, imm=0xFFF0 -> result=0xFFF0.
- reg_write_in=1, mem_write_in=1, reg_rd_in=0xA with flush=1 -> after edge reg_write_out=0, mem_write_out=0, reg_rd_out=0. Next edge with flush=0 -> values captured.
- funct=1000, rd1=0x8000, rd2=0x0004 -> result=0xF800. funct=0111 with the same operands -> 0x0800. funct=1100 -> operation=1111, result=0.

Source files
------------

// File: rtl/execute_stage.sv
// ----------------------------------------------------------------------------
// execute_stage
//   EX stage of the 16-bit pipelined CPU: ALU-control decode, a 16-bit signed
//   ALU and the EX/MEM pipeline register.
//
//   Optional feature macro: EXEC_ZERO_FLAG_EN
//     When defined, adds the combinational `zero` flag (result == 0) and its
//     registered copy `zero_out`, which is cleared by reset and flush.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   flush               next EX/MEM contents become a bubble
//   alu_op, funct       ALU control inputs
//   rd1, rd2, imm       operand 1, register operand 2, sign-extended immediate
//   alu_src             1: operand 2 = imm, 0: operand 2 = rd2
//   mov_op_in, reg_rd_in, *_in control bits   fields carried to EX/MEM
//   operation, result, remainder, overflow    combinational ALU outputs
//   alu_result_out ... reg_write_out          registered EX/MEM outputs
// ----------------------------------------------------------------------------
module execute_stage #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [1:0]       alu_op,
    input  logic [3:0]       funct,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    input  logic [WIDTH-1:0] imm,
    input  logic             alu_src,
    input  logic [3:0]       mov_op_in,
    input  logic [3:0]       reg_rd_in,
    input  logic             mem_to_reg_in,
    input  logic             mem_write_in,
    input  logic             mem_read_in,
    input  logic             r15_in,
    input  logic             reg_write_in,
    output logic [3:0]       operation,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             overflow,
`ifdef EXEC_ZERO_FLAG_EN
    output logic             zero,
    output logic             zero_out,
`endif
    output logic [WIDTH-1:0] alu_result_out,
    output logic [WIDTH-1:0] alu_remainder_out,
    output logic [3:0]       mov_op_out,
    output logic [3:0]       reg_rd_out,
    output logic             mem_to_reg_out,
    output logic             mem_write_out,
    output logic             mem_read_out,
    output logic             r15_out,
    output logic             reg_write_out
);

    // Operation encodings match the funct codes.
    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpAnd  = 4'b0010;
    localparam logic [3:0] OpOr   = 4'b0011;
    localparam logic [3:0] OpMul  = 4'b0100;
    localparam logic [3:0] OpDiv  = 4'b0101;
    localparam logic [3:0] OpSll  = 4'b0110;
    localparam logic [3:0] OpSrl  = 4'b0111;
    localparam logic [3:0] OpSra  = 4'b1000;
    localparam logic [3:0] OpPass = 4'b1001;
    localparam logic [3:0] OpNop  = 4'b1111;

    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // ALU control
    // ------------------------------------------------------------------
    always_comb begin
        operation = OpNop;
        case (alu_op)
            2'b00: operation = OpAdd;
            2'b01: operation = OpSub;
            2'b11: operation = OpPass;
            default: begin
                if (funct <= OpPass) begin
                    operation = funct;
                end else begin
                    operation = OpNop;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ALU datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]          b_op;
    logic signed [WIDTH-1:0]   a_s;
    logic signed [WIDTH-1:0]   b_s;
    logic [WIDTH-1:0]          sum;
    logic [WIDTH-1:0]          diff;
    logic signed [2*WIDTH-1:0] product;
    logic [3:0]                shamt;

    always_comb begin
        b_op    = alu_src ? imm : rd2;
        a_s     = $signed(rd1);
        b_s     = $signed(b_op);
        sum     = rd1 + b_op;
        diff    = rd1 - b_op;
        // Sign-extend both operands so the full double-width product is kept.
        product = (2*WIDTH)'(a_s) * (2*WIDTH)'(b_s);
        shamt   = b_op[3:0];
    end

    always_comb begin
        result    = '0;
        remainder = '0;
        overflow  = 1'b0;
        unique case (operation)
            OpAdd: begin
                result   = sum;
                overflow = (rd1[WIDTH-1] == b_op[WIDTH-1]) &&
                           (sum[WIDTH-1] != rd1[WIDTH-1]);
            end
            OpSub: begin
                result   = diff;
                overflow = (rd1[WIDTH-1] != b_op[WIDTH-1]) &&
                           (diff[WIDTH-1] != rd1[WIDTH-1]);
            end
            OpAnd: result = rd1 & b_op;
            OpOr:  result = rd1 | b_op;
            OpMul: begin
                result    = product[WIDTH-1:0];
                remainder = product[2*WIDTH-1:WIDTH];
                overflow  = product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}};
            end
            OpDiv: begin
                if (b_op == '0) begin
                    result    = '0;
                    remainder = rd1;
                    overflow  = 1'b1;
                end else if ((rd1 == MinNeg) && (b_op == '1)) begin
                    // Quotient +32768 is not representable.
                    result    = MinNeg;
                    remainder = '0;
                    overflow  = 1'b1;
                end else begin
                    result    = a_s / b_s;
                    remainder = a_s % b_s;
                end
            end
            OpSll:  result = rd1 << shamt;
            OpSrl:  result = rd1 >> shamt;
            OpSra:  result = a_s >>> shamt;
            OpPass: result = b_op;
            default: result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // EX/MEM pipeline register
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] alu_result_d, alu_result_q;
    logic [WIDTH-1:0] alu_remainder_d, alu_remainder_q;
    logic [3:0]       mov_op_d, mov_op_q;
    logic [3:0]       reg_rd_d, reg_rd_q;
    logic             mem_to_reg_d, mem_to_reg_q;
    logic             mem_write_d, mem_write_q;
    logic             mem_read_d, mem_read_q;
    logic             r15_d, r15_q;
    logic             reg_write_d, reg_write_q;
`ifdef EXEC_ZERO_FLAG_EN
    logic             zero_d, zero_q;

    assign zero = (result == '0);
`endif

    always_comb begin
        alu_result_d    = result;
        alu_remainder_d = remainder;
        mov_op_d        = mov_op_in;
        reg_rd_d        = reg_rd_in;
        mem_to_reg_d    = mem_to_reg_in;
        mem_write_d     = mem_write_in;
        mem_read_d      = mem_read_in;
        r15_d           = r15_in;
        reg_write_d     = reg_write_in;
`ifdef EXEC_ZERO_FLAG_EN
        zero_d          = zero;
`endif
        if (flush) begin
            alu_result_d    = '0;
            alu_remainder_d = '0;
            mov_op_d        = '0;
            reg_rd_d        = '0;
            mem_to_reg_d    = 1'b0;
            mem_write_d     = 1'b0;
            mem_read_d      = 1'b0;
            r15_d           = 1'b0;
            reg_write_d     = 1'b0;
`ifdef EXEC_ZERO_FLAG_EN
            zero_d          = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_result_q    <= '0;
            alu_remainder_q <= '0;
            mov_op_q        <= '0;
            reg_rd_q        <= '0;
            mem_to_reg_q    <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_read_q      <= 1'b0;
            r15_q           <= 1'b0;
            reg_write_q     <= 1'b0;
`ifdef EXEC_ZERO_FLAG_EN
            zero_q          <= 1'b0;
`endif
        end else begin
            alu_result_q    <= alu_result_d;
            alu_remainder_q <= alu_remainder_d;
            mov_op_q        <= mov_op_d;
            reg_rd_q        <= reg_rd_d;
            mem_to_reg_q    <= mem_to_reg_d;
            mem_write_q     <= mem_write_d;
            mem_read_q      <= mem_read_d;
            r15_q           <= r15_d;
            reg_write_q     <= reg_write_d;
`ifdef EXEC_ZERO_FLAG_EN
            zero_q          <= zero_d;
`endif
        end
    end

    assign alu_result_out    = alu_result_q;
    assign alu_remainder_out = alu_remainder_q;
    assign mov_op_out        = mov_op_q;
    assign reg_rd_out        = reg_rd_q;
    assign mem_to_reg_out    = mem_to_reg_q;
    assign mem_write_out     = mem_write_q;
    assign mem_read_out      = mem_read_q;
    assign r15_out           = r15_q;
    assign reg_write_out     = reg_write_q;
`ifdef EXEC_ZERO_FLAG_EN
    assign zero_out          = zero_q;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// ----------------------------------------------------------------------------
// tb_execute_stage
//   Scoreboard bench for execute_stage. The driver applies a vector at the
//   falling edge and queues the expected response from an integer-arithmetic
//   reference model; the monitor checks combinational and EX/MEM outputs
//   just after each rising edge. Supports EXEC_ZERO_FLAG_EN.
// ----------------------------------------------------------------------------
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [1:0]  alu_op;
    logic [3:0]  funct;
    logic [15:0] rd1, rd2, imm;
    logic        alu_src;
    logic [3:0]  mov_op_in, reg_rd_in;
    logic        mem_to_reg_in, mem_write_in, mem_read_in, r15_in, reg_write_in;
    logic [3:0]  operation;
    logic [15:0] result, remainder;
    logic        overflow;
    logic [15:0] alu_result_out, alu_remainder_out;
    logic [3:0]  mov_op_out, reg_rd_out;
    logic        mem_to_reg_out, mem_write_out, mem_read_out, r15_out, reg_write_out;
`ifdef EXEC_ZERO_FLAG_EN
    logic        zero, zero_out;
`endif

    execute_stage #(.WIDTH(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .alu_op            (alu_op),
        .funct             (funct),
        .rd1               (rd1),
        .rd2               (rd2),
        .imm               (imm),
        .alu_src           (alu_src),
        .mov_op_in         (mov_op_in),
        .reg_rd_in         (reg_rd_in),
        .mem_to_reg_in     (mem_to_reg_in),
        .mem_write_in      (mem_write_in),
        .mem_read_in       (mem_read_in),
        .r15_in            (r15_in),
        .reg_write_in      (reg_write_in),
        .operation         (operation),
        .result            (result),
        .remainder         (remainder),
        .overflow          (overflow),
`ifdef EXEC_ZERO_FLAG_EN
        .zero              (zero),
        .zero_out          (zero_out),
`endif
        .alu_result_out    (alu_result_out),
        .alu_remainder_out (alu_remainder_out),
        .mov_op_out        (mov_op_out),
        .reg_rd_out        (reg_rd_out),
        .mem_to_reg_out    (mem_to_reg_out),
        .mem_write_out     (mem_write_out),
        .mem_read_out      (mem_read_out),
        .r15_out           (r15_out),
        .reg_write_out     (reg_write_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] res;
        logic [15:0] rem;
        logic        ovf;
        logic [15:0] q_res;
        logic [15:0] q_rem;
        logic [3:0]  q_mov;
        logic [3:0]  q_rd;
        logic [4:0]  q_ctl;  // {mem_to_reg, mem_write, mem_read, r15, reg_write}
        logic        q_zero;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_mis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain signed integer arithmetic on the operation table.
    function automatic exp_t model(input logic [1:0] aop, input logic [3:0] fn,
                                   input logic [15:0] r1, input logic [15:0] r2,
                                   input logic [15:0] im, input logic src, input logic fl,
                                   input logic [3:0] mov, input logic [3:0] rd,
                                   input logic [4:0] ctl);
        exp_t   e;
        longint a, b, p, q, r;
        logic [15:0] bu;
        int     sh;
        bu = src ? im : r2;
        a  = longint'($signed(r1));
        b  = longint'($signed(bu));
        sh = int'(bu[3:0]);
        if (aop == 2'b00)      e.op = 4'd0;
        else if (aop == 2'b01) e.op = 4'd1;
        else if (aop == 2'b11) e.op = 4'd9;
        else                   e.op = (fn <= 4'd9) ? fn : 4'd15;
        e.res = 16'h0;
        e.rem = 16'h0;
        e.ovf = 1'b0;
        case (e.op)
            4'd0: begin p = a + b; e.res = p[15:0]; e.ovf = (p > 32767) || (p < -32768); end
            4'd1: begin p = a - b; e.res = p[15:0]; e.ovf = (p > 32767) || (p < -32768); end
            4'd2: e.res = r1 & bu;
            4'd3: e.res = r1 | bu;
            4'd4: begin
                p = a * b;
                e.res = p[15:0];
                e.rem = p[31:16];
                e.ovf = (p > 32767) || (p < -32768);
            end
            4'd5: begin
                if (b == 0) begin
                    e.rem = r1;
                    e.ovf = 1'b1;
                end else if (a == -32768 && b == -1) begin
                    e.res = 16'h8000;
                    e.ovf = 1'b1;
                end else begin
                    q = a / b;
                    r = a % b;
                    e.res = q[15:0];
                    e.rem = r[15:0];
                end
            end
            4'd6: begin p = longint'(r1) << sh; e.res = p[15:0]; end
            4'd7: begin p = longint'(r1) >> sh; e.res = p[15:0]; end
            4'd8: begin p = a >>> sh; e.res = p[15:0]; end
            4'd9: e.res = bu;
            default: e.res = 16'h0;
        endcase
        if (fl) begin
            e.q_res = '0; e.q_rem = '0; e.q_mov = '0; e.q_rd = '0; e.q_ctl = '0; e.q_zero = 1'b0;
        end else begin
            e.q_res = e.res; e.q_rem = e.rem; e.q_mov = mov; e.q_rd = rd; e.q_ctl = ctl;
            e.q_zero = (e.res == 16'h0);
        end
        return e;
    endfunction

    task automatic drive(input logic [1:0] aop, input logic [3:0] fn, input logic [15:0] r1,
                         input logic [15:0] r2, input logic [15:0] im, input logic src,
                         input logic fl, input logic [3:0] mov, input logic [3:0] rd,
                         input logic [4:0] ctl);
        @(negedge clk);
        alu_op = aop; funct = fn; rd1 = r1; rd2 = r2; imm = im; alu_src = src; flush = fl;
        mov_op_in = mov; reg_rd_in = rd;
        {mem_to_reg_in, mem_write_in, mem_read_in, r15_in, reg_write_in} = ctl;
        sb.push_back(model(aop, fn, r1, r2, im, src, fl, mov, rd, ctl));
    endtask

    task automatic check_regs_zero(input string nm);
        chk({nm, "_res"}, 32'(alu_result_out), 32'h0);
        chk({nm, "_rem"}, 32'(alu_remainder_out), 32'h0);
        chk({nm, "_fields"}, 32'({mov_op_out, reg_rd_out}), 32'h0);
        chk({nm, "_ctl"}, 32'({mem_to_reg_out, mem_write_out, mem_read_out, r15_out,
                               reg_write_out}), 32'h0);
`ifdef EXEC_ZERO_FLAG_EN
        chk({nm, "_zero_out"}, 32'(zero_out), 32'h0);
`endif
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #2;
        n_vec++;
        if (sb.size() != 0) begin
            n_mis++;
            $display("FAIL drain: %0d expected responses never checked", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [15:0] rnd_val();
        logic [15:0] v;
        case ($urandom_range(0, 7))
            0: v = 16'h0000;
            1: v = 16'h8000;
            2: v = 16'hFFFF;
            3: v = 16'h7FFF;
            4: v = 16'(($urandom_range(0, 31)) - 16);
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    // Monitor: one expected response per rising edge while the queue is non-empty.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("operation", 32'(operation), 32'(e.op));
                chk("result", 32'(result), 32'(e.res));
                chk("remainder", 32'(remainder), 32'(e.rem));
                chk("overflow", 32'(overflow), 32'(e.ovf));
                chk("alu_result_out", 32'(alu_result_out), 32'(e.q_res));
                chk("alu_remainder_out", 32'(alu_remainder_out), 32'(e.q_rem));
                chk("mov_op_out", 32'(mov_op_out), 32'(e.q_mov));
                chk("reg_rd_out", 32'(reg_rd_out), 32'(e.q_rd));
                chk("ctl_out", 32'({mem_to_reg_out, mem_write_out, mem_read_out, r15_out,
                                    reg_write_out}), 32'(e.q_ctl));
`ifdef EXEC_ZERO_FLAG_EN
                chk("zero", 32'(zero), 32'(e.res == 16'h0));
                chk("zero_out", 32'(zero_out), 32'(e.q_zero));
`endif
            end
        end
    end

    initial begin
        reset = 1'b0; flush = 1'b0; alu_op = 2'b00; funct = 4'h0;
        rd1 = 16'h1111; rd2 = 16'h2222; imm = 16'h3333; alu_src = 1'b0;
        mov_op_in = 4'hF; reg_rd_in = 4'hF;
        {mem_to_reg_in, mem_write_in, mem_read_in, r15_in, reg_write_in} = 5'h1F;
        // A rising edge passes at t=5 with reset held low.
        #7;
        check_regs_zero("reset_hold");
        @(negedge clk);
        reset = 1'b1;

        // Directed cases
        drive(2'b10, 4'b0000, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 1'b0, 4'h1, 4'h2, 5'h01);
        drive(2'b10, 4'b0001, 16'h0003, 16'h0005, 16'h0, 1'b0, 1'b0, 4'h3, 4'h4, 5'h02);
        drive(2'b10, 4'b0100, 16'h0100, 16'h0100, 16'h0, 1'b0, 1'b0, 4'h5, 4'h6, 5'h04);
        drive(2'b10, 4'b0101, 16'hFFF9, 16'h0002, 16'h0, 1'b0, 1'b0, 4'h7, 4'h8, 5'h08);
        drive(2'b10, 4'b0101, 16'h1234, 16'h0000, 16'h0, 1'b0, 1'b0, 4'h9, 4'h1, 5'h10);
        drive(2'b10, 4'b0101, 16'h8000, 16'hFFFF, 16'h0, 1'b0, 1'b0, 4'h2, 4'h3, 5'h11);
        drive(2'b11, 4'b0000, 16'h1111, 16'h2222, 16'hFFF0, 1'b1, 1'b0, 4'h4, 4'h5, 5'h1F);
        drive(2'b00, 4'b0000, 16'h0001, 16'h0002, 16'h0, 1'b0, 1'b1, 4'h6, 4'hA, 5'h19);
        drive(2'b00, 4'b0000, 16'h0001, 16'h0002, 16'h0, 1'b0, 1'b0, 4'h6, 4'hA, 5'h19);
        drive(2'b10, 4'b1000, 16'h8000, 16'h0004, 16'h0, 1'b0, 1'b0, 4'h1, 4'h1, 5'h00);
        drive(2'b10, 4'b0111, 16'h8000, 16'h0004, 16'h0, 1'b0, 1'b0, 4'h1, 4'h1, 5'h00);
        drive(2'b10, 4'b1100, 16'h8000, 16'h0004, 16'h0, 1'b0, 1'b0, 4'h1, 4'h1, 5'h00);
        drive(2'b10, 4'b0110, 16'h8001, 16'h00F1, 16'h0, 1'b0, 1'b0, 4'h1, 4'h1, 5'h00);

        // Leave nonzero state, then assert reset between clock edges.
        drive(2'b00, 4'b0000, 16'h1234, 16'h0001, 16'h0, 1'b0, 1'b0, 4'hC, 4'hD, 5'h1F);
        drain();
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_regs_zero("reset_async");
        @(negedge clk);
        reset = 1'b1;
        drive(2'b00, 4'b0000, 16'h0005, 16'h0003, 16'h0, 1'b0, 1'b0, 4'h2, 4'h7, 5'h01);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(2'($urandom), 4'($urandom), rnd_val(), rnd_val(), rnd_val(),
                  1'($urandom), ($urandom_range(0, 7) == 0), 4'($urandom), 4'($urandom),
                  5'($urandom));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
